keccak_sponge_ctrl: RTL

Sponge sequencer for the Keccak engine. It latches the mode-derived rate and suffix (driven by keccak_param_unit), absorbs 64-bit message lanes into the state array, and inserts SHA-3/SHAKE padding. It starts the permutation core once per rate block, then squeezes the requested number of output lanes. It sits between the message/digest stream interfaces and the state array and permutation core.

---
 rtl/keccak_sponge_ctrl.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/keccak_sponge_ctrl.sv
// Keccak sponge sequencer: absorbs 64-bit message lanes, applies SHA-3/SHAKE
// padding, starts the permutation once per rate block and squeezes digest lanes.
module keccak_sponge_ctrl #(
  parameter int LANE_W         = 64,
  parameter int OUT_LEN_W      = 16,
  parameter int MODE_SEL_WIDTH = 2,
  parameter int RATE_WIDTH     = 11,
  parameter int SUFFIX_WIDTH   = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start_i,
  input  logic [MODE_SEL_WIDTH-1:0] keccak_mode_i,
  input  logic [RATE_WIDTH-1:0]     rate_i,
  input  logic [SUFFIX_WIDTH-1:0]   suffix_i,
  input  logic [OUT_LEN_W-1:0]      out_lanes_i,
  input  logic                      msg_valid_i,
  output logic                      msg_ready_o,
  input  logic [LANE_W-1:0]         msg_data_i,
  input  logic                      msg_last_i,
  input  logic [3:0]                msg_bytes_i,
  output logic                      st_wr_en_o,
  output logic [4:0]                st_lane_idx_o,
  output logic [LANE_W-1:0]         st_xor_data_o,
  input  logic [LANE_W-1:0]         st_rd_data_i,
  output logic                      perm_start_o,
  input  logic                      perm_done_i,
  output logic                      out_valid_o,
  input  logic                      out_ready_i,
  output logic [LANE_W-1:0]         out_data_o,
  output logic                      busy_o,
  output logic                      done_o
);

  localparam logic [MODE_SEL_WIDTH-1:0] MODE_SHA3_256 = MODE_SEL_WIDTH'(0);
  localparam logic [MODE_SEL_WIDTH-1:0] MODE_SHA3_512 = MODE_SEL_WIDTH'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_ABSORB, S_PAD, S_PERM, S_SQUEEZE, S_SQ_PERM, S_DONE
  } state_t;

  state_t                  r_state;
  state_t                  w_next;
  logic [4:0]              r_rateLanes;
  logic [SUFFIX_WIDTH-1:0] r_suffix;
  logic [OUT_LEN_W-1:0]    r_outRem;
  logic [4:0]              r_laneCnt;
  logic [4:0]              r_sqCnt;
  logic                    r_msgEnded;
  logic                    r_padDone;
  logic                    r_sufPend;
  logic [4:0]              r_sufLane;
  logic                    r_permIssued;

  logic [4:0]        w_lastIdx;
  logic [4:0]        w_laneInc;
  logic [4:0]        w_sqInc;
  logic              w_partial;
  logic [5:0]        w_byteShift;
  logic [LANE_W-1:0] w_mask;
  logic [LANE_W-1:0] w_padHi;
  logic [LANE_W-1:0] w_absorbData;
  logic              w_startOk;

  assign w_lastIdx   = r_rateLanes - 5'd1;
  assign w_laneInc   = r_laneCnt + 5'd1;
  assign w_sqInc     = r_sqCnt + 5'd1;
  assign w_startOk   = start_i && (rate_i != '0);
  assign w_partial   = msg_last_i && (msg_bytes_i < 4'd8);
  assign w_byteShift = {msg_bytes_i[2:0], 3'b000};
  assign w_mask      = (LANE_W'(1) << w_byteShift) - LANE_W'(1);
  assign w_padHi     = LANE_W'(8'h80) << (LANE_W - 8);

  // A short final lane carries the suffix right after its data bytes, and the
  // closing 0x80 too when it is also the last lane of the block.
  assign w_absorbData = w_partial
    ? ((msg_data_i & w_mask) | (LANE_W'(r_suffix) << w_byteShift) |
       ((r_laneCnt == w_lastIdx) ? w_padHi : '0))
    : msg_data_i;

  always_comb begin
    w_next        = r_state;
    msg_ready_o   = 1'b0;
    st_wr_en_o    = 1'b0;
    st_lane_idx_o = '0;
    st_xor_data_o = '0;
    perm_start_o  = 1'b0;
    out_valid_o   = 1'b0;
    out_data_o    = '0;
    busy_o        = (r_state != S_IDLE);
    done_o        = 1'b0;
    case (r_state)
      S_IDLE: if (w_startOk) w_next = S_ABSORB;
      S_ABSORB: begin
        msg_ready_o   = 1'b1;
        st_lane_idx_o = r_laneCnt;
        if (msg_valid_i) begin
          st_wr_en_o    = 1'b1;
          st_xor_data_o = w_absorbData;
          if (w_laneInc == r_rateLanes) w_next = S_PERM;
          else if (msg_last_i)          w_next = S_PAD;
        end
      end
      S_PAD: begin
        st_wr_en_o = 1'b1;
        if (r_sufPend) begin
          st_lane_idx_o = r_sufLane;
          st_xor_data_o = LANE_W'(r_suffix) | ((r_sufLane == w_lastIdx) ? w_padHi : '0);
          if (r_sufLane == w_lastIdx) w_next = S_PERM;
        end else begin
          st_lane_idx_o = w_lastIdx;
          st_xor_data_o = w_padHi;
          w_next        = S_PERM;
        end
      end
      S_PERM: begin
        perm_start_o = !r_permIssued;
        if (r_permIssued && perm_done_i)
          w_next = r_padDone ? S_SQUEEZE : (r_msgEnded ? S_PAD : S_ABSORB);
      end
      S_SQUEEZE: begin
        if (r_outRem == '0) begin
          w_next = S_DONE;
        end else begin
          out_valid_o   = 1'b1;
          st_lane_idx_o = r_sqCnt;
          out_data_o    = st_rd_data_i;
          if (out_ready_i) begin
            if (r_outRem == OUT_LEN_W'(1))  w_next = S_DONE;
            else if (w_sqInc == r_rateLanes) w_next = S_SQ_PERM;
          end
        end
      end
      S_SQ_PERM: begin
        perm_start_o = !r_permIssued;
        if (r_permIssued && perm_done_i) w_next = S_SQUEEZE;
      end
      S_DONE: begin
        done_o = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath registers; r_permIssued marks that the start pulse has been sent
  // so perm_done_i is only believed from the following cycle on.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_rateLanes  <= '0;
      r_suffix     <= '0;
      r_outRem     <= '0;
      r_laneCnt    <= '0;
      r_sqCnt      <= '0;
      r_msgEnded   <= 1'b0;
      r_padDone    <= 1'b0;
      r_sufPend    <= 1'b0;
      r_sufLane    <= '0;
      r_permIssued <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_permIssued <= (w_next == r_state) && (r_state == S_PERM || r_state == S_SQ_PERM);
      case (r_state)
        S_IDLE: if (w_startOk) begin
          r_rateLanes <= 5'(rate_i >> 6);
          r_suffix    <= suffix_i;
          if (keccak_mode_i == MODE_SHA3_256)      r_outRem <= OUT_LEN_W'(4);
          else if (keccak_mode_i == MODE_SHA3_512) r_outRem <= OUT_LEN_W'(8);
          else                                     r_outRem <= out_lanes_i;
          r_laneCnt  <= '0;
          r_sqCnt    <= '0;
          r_msgEnded <= 1'b0;
          r_padDone  <= 1'b0;
          r_sufPend  <= 1'b0;
          r_sufLane  <= '0;
        end
        S_ABSORB: if (msg_valid_i) begin
          r_laneCnt <= w_laneInc;
          if (msg_last_i) begin
            r_msgEnded <= 1'b1;
            if (w_partial) begin
              r_padDone <= (r_laneCnt == w_lastIdx);
            end else begin
              r_sufPend <= 1'b1;
              r_sufLane <= (r_laneCnt == w_lastIdx) ? 5'd0 : w_laneInc;
            end
          end
        end
        S_PAD: begin
          if (r_sufPend) begin
            r_sufPend <= 1'b0;
            if (r_sufLane == w_lastIdx) r_padDone <= 1'b1;
          end else begin
            r_padDone <= 1'b1;
          end
        end
        S_PERM: if (r_permIssued && perm_done_i) begin
          r_sqCnt <= '0;
          if (!r_padDone && !r_msgEnded) r_laneCnt <= '0;
        end
        S_SQUEEZE: if (r_outRem != '0 && out_ready_i) begin
          r_outRem <= r_outRem - OUT_LEN_W'(1);
          r_sqCnt  <= w_sqInc;
        end
        S_SQ_PERM: if (r_permIssued && perm_done_i) r_sqCnt <= '0;
        default: ;
      endcase
    end
  end

endmodule
